uart_reg_arb: RTL and testbench
===============================

# uart_reg_arb

Two-port arbiter that shares the UART 8-bit register bus (4-bit address, single byte lane) between two requesters: port 0 (CPU bridge) and port 1 (boot/console sequencer). It sits directly in front of the UART configuration block's `reg_cs`/`reg_wr`/`reg_addr`/`reg_wdata`/`reg_be` inputs. It serialises accesses with round-robin fairness and holds each access until the slave acknowledges. It then forces one idle cycle so the slave's ack/FIFO-pop logic cannot fire twice, and completes any hung access with an error after a programmable timeout.

## Interface
Parameters:
- `TO_W`, default 4: timeout counter width; an access aborts after 2^TO_W−1 cycles in ACCESS without `s_ack`.

Ports:
- `mclk`, input, 1: clock.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `mN_cs`, input, 1 (N = 0, 1): request; held high until `mN_ack`.
- `mN_wr`, input, 1: 1 = write, 0 = read.
- `mN_addr`, input, 4: register address.
- `mN_wdata`, input, 8: write data.
- `mN_be`, input, 1: byte enable.
- `mN_rdata`, output, 8: read data; valid while `mN_ack` = 1.
- `mN_ack`, output, 1: one-cycle completion pulse.
- `mN_err`, output, 1: qualifies `mN_ack`; 1 = timeout abort.
- `s_cs`, `s_wr`, `s_be`, output, 1 each: to the UART register bus.
- `s_addr`, output, 4: to the UART register bus.
- `s_wdata`, output, 8: to the UART register bus.
- `s_rdata`, input, 8: from the UART register bus.
- `s_ack`, input, 1: from the UART register bus.

## Operation
- The FSM has three states: IDLE, ACCESS, RELEASE.
- **IDLE**
  - `s_cs` = 0.
  - If any `mN_cs` = 1, grant one port and latch its `wr`/`addr`/`wdata`/`be` into the slave-side registers.
  - Clear the timeout counter and go to ACCESS.
- **Grant rule**
  - A single requester always wins.
  - If both request, the port not granted last wins.
  - The `last` pointer resets to 1, so port 0 wins the first contention.
  - The pointer updates on every grant.
- **ACCESS**
  - `s_cs` = 1 with the latched fields held stable.
  - On `s_ack` = 1: capture `s_rdata` (0 for writes), go to RELEASE, and schedule the granted `mN_ack` with `mN_err` = 0.
  - `s_cs` stays 1 in the `s_ack` cycle. This is required so the UART's TX-FIFO write and RX-FIFO pop qualify.
  - Otherwise increment the counter. When it reaches 2^TO_W−1, go to RELEASE with `mN_err` = 1 and `mN_rdata` = 0.
- **RELEASE**
  - `s_cs` = 0 for exactly one cycle.
  - The granted `mN_ack` = 1 with `mN_rdata`/`mN_err` valid. The non-granted ack stays 0.
  - Next state is IDLE.
- **Requester rules**
  - A requester drops `mN_cs` the cycle after seeing `mN_ack`, or keeps it high to issue a new access.
  - `mN_cs` is sampled only in IDLE.
  - If a requester drops `cs` early, the latched access still completes and the ack is still pulsed.
- **Field ownership**: changes to a granted port's fields after the grant are ignored until the next grant.

## Timing
- Reset values: all outputs 0, state IDLE, `last` = 1, counter 0.
- Reset mid-access: the access is abandoned, `s_cs` drops asynchronously, and no ack is issued.
- Latency with the UART slave (ack one cycle after `cs`):
  - cycle 0: `mN_cs` sampled in IDLE.
  - cycle 1: `s_cs` = 1.
  - cycle 2: `s_ack` = 1.
  - cycle 3: `mN_ack` = 1 and `s_cs` = 0.
  - cycle 4: next grant possible.
- Throughput is one access per 4 cycles.
- All outputs are registered; there is no combinational path from `mN_*` or `s_*` to any output.
- `s_ack` arriving outside ACCESS is ignored.
- If the counter hits terminal count in the same cycle as `s_ack`, `s_ack` wins: normal completion, `err` = 0.
- The counter is TO_W bits, saturates at terminal count, and never wraps.

## Structure
- Package `uart_reg_arb_pkg` holds:
  - the state enum typedef (IDLE, ACCESS, RELEASE);
  - a packed request struct (wr, addr[3:0], wdata[7:0], be);
  - the default `TO_W`.
- Sub-module `uart_rr_arb2`: a 2-way round-robin grant with the `last` pointer register. Inputs are `req[1:0]` and `update`; output is a one-hot `gnt[1:0]`.
- The top level contains the FSM, latches, timeout counter and response registers.

## Test plan
- **Single read:** m0 reads addr 4 with the slave returning 8'h02. `s_cs` is high in cycles 1–2 only; `m0_ack` is high in cycle 3 with `m0_rdata` = 8'h02 and `m0_err` = 0.
- **Contention:** m0 and m1 both request continuously. Grants alternate m0, m1, m0, m1; `s_cs` is low for one cycle between accesses and neither ack overlaps.
- **TX FIFO write:** m1 writes 8'h41 to addr 5. `s_wr`/`s_addr` = 5 and `s_wdata` = 8'h41 are held stable through the `s_ack` cycle; exactly one `s_cs`-high-with-`s_ack` cycle occurs.
- **Timeout:** with TO_W = 4 and the slave never acking, `m0_ack` fires with `m0_err` = 1 and `rdata` = 0 after 15 ACCESS cycles. The arbiter returns to IDLE and then serves a pending m1.
- **Reset during ACCESS:** assert `reset_n` = 0 mid-access. `s_cs` drops immediately, no `mN_ack` occurs, and after release m0 wins the first contention.
- **Early drop:** m0 drops `cs` in cycle 2. The access still completes and `m0_ack` pulses in cycle 3.

Source files
------------

// File: rtl/uart_reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_reg_arb_pkg
// Description : Shared types for the UART register-bus arbiter. Defines the
//               arbiter FSM state encoding, the packed register-access
//               request latched at grant time, and the default timeout
//               counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_reg_arb_pkg;

  // Default width of the ACCESS timeout counter. Terminal count is 2^W-1.
  localparam int TO_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // One register-bus access as presented by a requester.
  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       be;
  } reg_req_t;

endpackage
`default_nettype wire

// File: rtl/uart_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_arb2
// Description : Two-way round-robin grant. A lone requester always wins;
//               under contention the port not granted last wins. The 'last'
//               pointer resets to 1 so port 0 wins the first contention.
// Ports       : mclk, reset_n  - clock, async active-low reset
//               req[1:0]       - request vector (bit N = port N)
//               update         - advance the pointer to the current winner
//               gnt[1:0]       - one-hot grant (combinational from req)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_arb2 (
  input  logic       mclk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Only a real grant moves the pointer; an empty update leaves it alone.
  always_comb begin
    last_d = last_q;
    if (update && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_reg_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_reg_arb
// Description : Shares the UART 8-bit register bus between two requesters
//               (port 0 CPU bridge, port 1 boot/console sequencer). Accesses
//               are serialised round-robin, held until s_ack, followed by one
//               forced idle cycle, and aborted with err after 2^TO_W-1
//               ACCESS cycles without an ack. All outputs are registered.
// Ports       : mclk, reset_n           - clock, async active-low reset
//               mN_cs/wr/addr/wdata/be  - requester N access (N = 0, 1)
//               mN_rdata/ack/err        - requester N completion
//               s_cs/wr/addr/wdata/be   - to UART register bus
//               s_rdata, s_ack          - from UART register bus
// Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_arb
  import uart_reg_arb_pkg::*;
#(
  parameter int TO_W = TO_W_DEFAULT
) (
  input  logic       mclk,
  input  logic       reset_n,
  input  logic       m0_cs,
  input  logic       m0_wr,
  input  logic [3:0] m0_addr,
  input  logic [7:0] m0_wdata,
  input  logic       m0_be,
  output logic [7:0] m0_rdata,
  output logic       m0_ack,
  output logic       m0_err,
  input  logic       m1_cs,
  input  logic       m1_wr,
  input  logic [3:0] m1_addr,
  input  logic [7:0] m1_wdata,
  input  logic       m1_be,
  output logic [7:0] m1_rdata,
  output logic       m1_ack,
  output logic       m1_err,
  output logic       s_cs,
  output logic       s_wr,
  output logic [3:0] s_addr,
  output logic [7:0] s_wdata,
  output logic       s_be,
  input  logic [7:0] s_rdata,
  input  logic       s_ack
);

  localparam logic [TO_W-1:0] CNT_TC = {TO_W{1'b1}};

  arb_state_t      state_q, state_d;
  reg_req_t        req_q, req_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            sel_q, sel_d;
  logic            s_cs_q, s_cs_d;
  logic [1:0]      ack_q, ack_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;

  reg_req_t        m0_req, m1_req;
  logic            grant_en;
  logic [1:0]      arb_req;
  logic [1:0]      gnt;

  assign m0_req   = {m0_wr, m0_addr, m0_wdata, m0_be};
  assign m1_req   = {m1_wr, m1_addr, m1_wdata, m1_be};

  // Requests are only looked at in IDLE, so the arbiter sees nothing else.
  assign grant_en = (state_q == ST_IDLE);
  assign arb_req  = {m1_cs, m0_cs} & {2{grant_en}};

  uart_rr_arb2 u_rr_arb (
    .mclk    (mclk),
    .reset_n (reset_n),
    .req     (arb_req),
    .update  (grant_en),
    .gnt     (gnt)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    s_cs_d  = s_cs_q;
    ack_d   = 2'b00;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_inc = cnt_q + TO_W'(1);

    case (state_q)
      ST_IDLE: begin
        s_cs_d = 1'b0;
        if (gnt != 2'b00) begin
          sel_d   = gnt[1];
          req_d   = gnt[1] ? m1_req : m0_req;
          cnt_d   = '0;
          s_cs_d  = 1'b1;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // s_ack is checked first so it wins over a same-cycle terminal count.
        if (s_ack) begin
          s_cs_d       = 1'b0;
          ack_d[sel_q] = 1'b1;
          err_d        = 1'b0;
          rdata_d      = req_q.wr ? 8'h00 : s_rdata;
          state_d      = ST_RELEASE;
        end else begin
          if (cnt_q != CNT_TC) begin
            cnt_d = cnt_inc;
          end
          if ((cnt_inc == CNT_TC) || (cnt_q == CNT_TC)) begin
            s_cs_d       = 1'b0;
            ack_d[sel_q] = 1'b1;
            err_d        = 1'b1;
            rdata_d      = 8'h00;
            state_d      = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        // Forced idle cycle; response registers return to 0 afterwards.
        s_cs_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = 8'h00;
        state_d = ST_IDLE;
      end

      default: begin
        s_cs_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      s_cs_q  <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      s_cs_q  <= s_cs_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign s_cs     = s_cs_q;
  assign s_wr     = req_q.wr;
  assign s_addr   = req_q.addr;
  assign s_wdata  = req_q.wdata;
  assign s_be     = req_q.be;

  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_err   = err_q;
  assign m1_err   = err_q;
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_reg_arb
// Description : Self-checking bench for uart_reg_arb. A transaction-level
//               reference (grant time, completion time, latched request)
//               predicts the outputs every cycle; directed scenarios add
//               literal expectations; a randomized phase drives arbitrary
//               requester and slave behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_reg_arb;

  localparam int TO_W = 4;
  localparam int TMO  = (1 << TO_W) - 1;

  logic       mclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       m0_cs = 0, m0_wr = 0, m0_be = 0;
  logic [3:0] m0_addr = 0;
  logic [7:0] m0_wdata = 0;
  logic       m1_cs = 0, m1_wr = 0, m1_be = 0;
  logic [3:0] m1_addr = 0;
  logic [7:0] m1_wdata = 0;
  logic [7:0] m0_rdata, m1_rdata;
  logic       m0_ack, m0_err, m1_ack, m1_err;
  logic       s_cs, s_wr, s_be;
  logic [3:0] s_addr;
  logic [7:0] s_wdata;
  logic [7:0] s_rdata = 0;
  logic       s_ack = 0;

  int n_chk  = 0;
  int n_fail = 0;

  uart_reg_arb #(.TO_W(TO_W)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .m0_cs(m0_cs), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cs(m1_cs), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cs(s_cs), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave responder ----------------
  // mode 0: ack one cycle after s_cs rises; 1: never ack; 2: random ack
  int         slv_mode = 0;
  int         slv_pmax = 3;
  logic [7:0] slv_rdata = 8'h00;
  logic       scs_seen = 0, ack_seen = 0;

  always @(negedge mclk) begin
    scs_seen = s_cs;
    ack_seen = s_ack;
  end

  always @(posedge mclk) begin
    #1;
    case (slv_mode)
      0:       s_ack = scs_seen && !ack_seen;
      1:       s_ack = 1'b0;
      default: s_ack = ($urandom_range(0, slv_pmax) == 0);
    endcase
    s_rdata = (slv_mode == 2) ? 8'($urandom) : slv_rdata;
  end

  // ---------------- reference model ----------------
  // Tracks one transaction by absolute cycle numbers: grant cycle, then
  // completion cycle (s_ack or TMO cycles after grant), then one release
  // cycle before requests are looked at again.
  int         cyc = 0;
  bit         m_busy = 0;
  int         m_gcyc = 0, m_dcyc = -1;
  bit         m_who = 0, m_last = 1;
  logic       m_wr = 0, m_be = 0;
  logic [3:0] m_addr = 0;
  logic [7:0] m_wdata = 0, m_rdata = 0;
  bit         m_err = 0;
  bit         e_scs = 0;
  bit [1:0]   e_ack = 0;

  always @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_last = 1; m_dcyc = -1; e_scs = 0; e_ack = 0;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (m0_cs || m1_cs) begin
          m_who   = (m0_cs && m1_cs) ? !m_last : m1_cs;
          m_last  = m_who;
          m_wr    = m_who ? m1_wr    : m0_wr;
          m_addr  = m_who ? m1_addr  : m0_addr;
          m_wdata = m_who ? m1_wdata : m0_wdata;
          m_be    = m_who ? m1_be    : m0_be;
          m_busy  = 1; m_gcyc = cyc; m_dcyc = -1;
        end
      end else if (m_dcyc < 0) begin
        if (s_ack) begin
          m_dcyc = cyc; m_err = 0; m_rdata = m_wr ? 8'h00 : s_rdata;
        end else if (cyc - m_gcyc == TMO) begin
          m_dcyc = cyc; m_err = 1; m_rdata = 8'h00;
        end
      end else begin
        m_busy = 0;
      end
      e_scs = m_busy && (m_dcyc < 0);
      e_ack = 2'b00;
      if (m_busy && (m_dcyc == cyc)) e_ack[m_who] = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge mclk) begin
    check("s_cs", s_cs, e_scs);
    check("m0_ack", m0_ack, e_ack[0]);
    check("m1_ack", m1_ack, e_ack[1]);
    if (e_scs) begin
      check("s_wr", s_wr, m_wr);
      check("s_addr", s_addr, m_addr);
      check("s_wdata", s_wdata, m_wdata);
      check("s_be", s_be, m_be);
    end
    if (e_ack[0]) begin
      check("m0_rdata", m0_rdata, m_rdata);
      check("m0_err", m0_err, m_err);
    end
    if (e_ack[1]) begin
      check("m1_rdata", m1_rdata, m_rdata);
      check("m1_err", m1_err, m_err);
    end
    if (!reset_n) begin
      check("rst_outs", {s_wr, s_addr, s_wdata, s_be, m0_rdata, m0_err, m1_err}, 32'h0);
      check("rst_m1_rdata", m1_rdata, 8'h00);
    end
  end

  task automatic tick();
    @(posedge mclk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    int   n_gr;
    bit   seen;
    logic prev;
    logic [3:0] order [4];

    // ---- reset state ----
    idle(3);
    check("reset_s_cs", s_cs, 1'b0);
    check("reset_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'h0);
    check("reset_rdata", {m0_rdata, m1_rdata}, 16'h0);
    reset_n = 1'b1;
    idle(3);

    // ---- single read: m0 reads addr 4, slave returns 02 ----
    slv_mode = 0; slv_rdata = 8'h02;
    m0_cs = 1; m0_wr = 0; m0_addr = 4'd4; m0_be = 1;
    tick();                                   // cycle 1
    check("rd_c1_s_cs", s_cs, 1'b1);
    check("rd_c1_addr", s_addr, 4'd4);
    tick();                                   // cycle 2
    check("rd_c2_s_cs", s_cs, 1'b1);
    check("rd_c2_ack", m0_ack, 1'b0);
    tick();                                   // cycle 3
    check("rd_c3_s_cs", s_cs, 1'b0);
    check("rd_c3_ack", m0_ack, 1'b1);
    check("rd_c3_rdata", m0_rdata, 8'h02);
    check("rd_c3_err", m0_err, 1'b0);
    m0_cs = 0;
    tick();
    check("rd_c4_ack", m0_ack, 1'b0);
    idle(3);

    // ---- early drop: m0 drops cs in cycle 2 ----
    slv_rdata = 8'h33;
    m0_cs = 1; m0_addr = 4'd2;
    tick();
    tick();
    m0_cs = 0;
    tick();
    check("drop_ack", m0_ack, 1'b1);
    check("drop_rdata", m0_rdata, 8'h33);
    idle(3);

    // ---- TX FIFO write: m1 writes 41 to addr 5, fields scrambled after grant ----
    m1_cs = 1; m1_wr = 1; m1_addr = 4'd5; m1_wdata = 8'h41; m1_be = 1;
    cnt = 0;
    tick();                                   // cycle 1
    if (s_cs && s_ack) cnt++;
    m1_wr = 0; m1_addr = 4'hF; m1_wdata = 8'hEE;
    tick();                                   // cycle 2 (s_ack cycle)
    if (s_cs && s_ack) cnt++;
    check("tx_c2_wr", s_wr, 1'b1);
    check("tx_c2_addr", s_addr, 4'd5);
    check("tx_c2_wdata", s_wdata, 8'h41);
    tick();                                   // cycle 3
    if (s_cs && s_ack) cnt++;
    check("tx_ack", m1_ack, 1'b1);
    check("tx_rdata", m1_rdata, 8'h00);
    check("tx_cs_ack_cycles", cnt, 1);
    m1_cs = 0;
    idle(3);

    // ---- contention: both request continuously, m0 first ----
    m0_cs = 1; m0_wr = 0; m0_addr = 4'd1;
    m1_cs = 1; m1_wr = 0; m1_addr = 4'd2;
    n_gr = 0; prev = 0;
    for (int i = 0; i < 30 && n_gr < 4; i++) begin
      tick();
      if (s_cs && !prev) begin
        order[n_gr] = s_addr;
        n_gr++;
      end
      prev = s_cs;
    end
    m0_cs = 0; m1_cs = 0;
    check("cont_grants", n_gr, 4);
    check("cont_order", {order[0], order[1], order[2], order[3]}, 16'h1212);
    idle(6);

    // ---- timeout: slave never acks; m1 pending behind m0 ----
    slv_mode = 1;
    m0_cs = 1; m0_addr = 4'd3;
    m1_cs = 1; m1_addr = 4'd6;
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (s_cs) cnt++;
      if (m0_ack) begin
        seen = 1;
        check("to_err", m0_err, 1'b1);
        check("to_rdata", m0_rdata, 8'h00);
        m0_cs = 0; slv_mode = 0; slv_rdata = 8'h5A;
      end
    end
    check("to_seen", seen, 1'b1);
    check("to_access_cycles", cnt, TMO);
    seen = 0; prev = 0; n_gr = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (s_cs && !prev) order[0] = s_addr;
      prev = s_cs;
      if (m1_ack) begin
        seen = 1;
        check("to_m1_err", m1_err, 1'b0);
        check("to_m1_rdata", m1_rdata, 8'h5A);
        m1_cs = 0;
      end
    end
    check("to_m1_seen", seen, 1'b1);
    check("to_m1_addr", order[0], 4'd6);
    idle(3);

    // ---- reset during ACCESS ----
    slv_mode = 1;
    m0_cs = 1; m0_addr = 4'd7;
    m1_cs = 1; m1_addr = 4'd8;
    idle(3);
    #1 reset_n = 0;
    #1;
    check("rst_async_s_cs", s_cs, 1'b0);
    check("rst_async_acks", {m0_ack, m1_ack}, 2'b00);
    tick();
    check("rst_hold_acks", {m0_ack, m1_ack}, 2'b00);
    reset_n = 1; slv_mode = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (s_cs) begin
        seen = 1;
        check("rst_first_winner", s_addr, 4'd7);
      end
    end
    check("rst_regrant", seen, 1'b1);
    m0_cs = 0; m1_cs = 0;
    idle(6);

    // ---- randomized phase ----
    slv_mode = 2;
    for (int blk = 0; blk < 6; blk++) begin
      case (blk % 3)
        0:       slv_pmax = 1;
        1:       slv_pmax = 3;
        default: slv_pmax = 20;
      endcase
      for (int i = 0; i < 500; i++) begin
        m0_cs    = ($urandom_range(0, 9) < 6);
        m0_wr    = 1'($urandom);
        m0_addr  = 4'($urandom);
        m0_wdata = 8'($urandom);
        m0_be    = 1'($urandom);
        m1_cs    = ($urandom_range(0, 9) < 6);
        m1_wr    = 1'($urandom);
        m1_addr  = 4'($urandom);
        m1_wdata = 8'($urandom);
        m1_be    = 1'($urandom);
        tick();
      end
    end
    m0_cs = 0; m1_cs = 0; slv_mode = 0;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
